// File: rtl/retire_rat_pkg.sv
// Shared widths and types for the retirement RAT and its freed-PR return FIFO.
package retire_rat_pkg;
  localparam int SS         = 2;
  localparam int ARCH_REGS  = 32;
  localparam int PHYS_REGS  = 64;
  localparam int FREE_DEPTH = 8;
  localparam int PRW        = $clog2(PHYS_REGS);
  localparam int CNTW       = $clog2(SS + 1);

  typedef logic [PRW-1:0] preg_t;
  typedef logic [4:0]     areg_t;

  typedef struct packed {
    logic  valid;
    areg_t rd;
    preg_t pd;
  } commit_port_t;
endpackage

// File: rtl/retire_rat_if.sv
// Commit-side, free-list-side and committed-map signals of the retirement RAT.
interface retire_rat_if;
  import retire_rat_pkg::*;

  logic  [SS-1:0]        commit_valid;
  areg_t [SS-1:0]        commit_rd;
  preg_t [SS-1:0]        commit_pd;
  logic                  commit_stall;
  logic  [SS-1:0]        free_valid;
  preg_t [SS-1:0]        free_pr;
  logic  [SS-1:0]        free_ready;
  preg_t [ARCH_REGS-1:0] rrat_map;

  modport slave (
    input  commit_valid, commit_rd, commit_pd, free_ready,
    output commit_stall, free_valid, free_pr, rrat_map
  );

  modport master (
    output commit_valid, commit_rd, commit_pd, free_ready,
    input  commit_stall, free_valid, free_pr, rrat_map
  );
endinterface

// File: rtl/retire_rat_free_return_fifo.sv
// Multi-push/multi-pop freed-PR ring; outputs are combinational from storage (0-cycle read).
// Pops stop at the first slot not ready; o_full asks upstream to stall when fewer than SS slots remain.
module free_return_fifo
  import retire_rat_pkg::*;
#(
  parameter int SS_N  = 2,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(SS_N+1)-1:0]    i_push_cnt,
  input  preg_t [SS_N-1:0]             i_push_dat,
  output logic  [SS_N-1:0]             o_pop_vld,
  output preg_t [SS_N-1:0]             o_pop_dat,
  input  logic  [SS_N-1:0]             i_pop_rdy,
  output logic                         o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(SS_N + 1);

  preg_t          r_mem [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic [NW-1:0]  w_pop_cnt;
  logic           w_run;

  // Pop count is the length of the leading run of valid&&ready slots.
  always_comb begin
    w_pop_cnt = '0;
    w_run     = 1'b1;
    for (int k = 0; k < SS_N; k++) begin
      o_pop_vld[k] = (r_count > CW'(k));
      o_pop_dat[k] = r_mem[r_head + PW'(k)];
      if (w_run && o_pop_vld[k] && i_pop_rdy[k]) begin
        w_pop_cnt = w_pop_cnt + NW'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  assign o_full = (CW'(DEPTH) - r_count) < CW'(SS_N);

  always_ff @(posedge clk) begin
    for (int j = 0; j < SS_N; j++) begin
      if (NW'(j) < i_push_cnt) begin
        r_mem[r_tail + PW'(j)] <= i_push_dat[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop_cnt);
      r_tail  <= r_tail + PW'(i_push_cnt);
      r_count <= r_count + CW'(i_push_cnt) - CW'(w_pop_cnt);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (32'(r_count) + 32'(i_push_cnt)) <= DEPTH);
endmodule

// File: rtl/retire_rat.sv
// Retirement RAT: applies up to SS commits per cycle in slot order, map visible 1 cycle later.
// Stale PRs go to the free list through a buffered FIFO; commit_stall is driven from FIFO occupancy.
module retire_rat
  import retire_rat_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  retire_rat_if.slave  bus
);
  preg_t [ARCH_REGS-1:0] r_map;
  preg_t [ARCH_REGS-1:0] w_map;
  preg_t [SS-1:0]        w_push_dat;
  logic  [CNTW-1:0]      w_push_cnt;
  commit_port_t [SS-1:0] w_slot;
  logic                  w_stall;

  // Later slots see earlier slots' updates, so a repeated rd frees the earlier slot's pd.
  always_comb begin
    w_map      = r_map;
    w_push_dat = '0;
    w_push_cnt = '0;
    for (int i = 0; i < SS; i++) begin
      w_slot[i].valid = bus.commit_valid[i] && !w_stall;
      w_slot[i].rd    = bus.commit_rd[i];
      w_slot[i].pd    = bus.commit_pd[i];
      if (w_slot[i].valid && (w_slot[i].rd != '0)) begin
        for (int j = 0; j < SS; j++) begin
          if (CNTW'(j) == w_push_cnt) begin
            w_push_dat[j] = w_map[w_slot[i].rd];
          end
        end
        w_map[w_slot[i].rd] = w_slot[i].pd;
        w_push_cnt          = w_push_cnt + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_map[i] <= preg_t'(i);
      end
    end else begin
      r_map <= w_map;
    end
  end

  free_return_fifo #(
    .SS_N  (SS),
    .DEPTH (FREE_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_cnt (w_push_cnt),
    .i_push_dat (w_push_dat),
    .o_pop_vld  (bus.free_valid),
    .o_pop_dat  (bus.free_pr),
    .i_pop_rdy  (bus.free_ready),
    .o_full     (w_stall)
  );

  assign bus.commit_stall = w_stall;
  assign bus.rrat_map     = r_map;
endmodule

// File: tb/tb_retire_rat.sv
// Directed bench for retire_rat with a freed-PR scoreboard queue and a reference map model.
module tb_retire_rat;
  import retire_rat_pkg::*;

  logic clk;
  logic rst;
  retire_rat_if bus ();

  retire_rat dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    nvec = 0;
  int    nerr = 0;
  preg_t q[$];
  preg_t m [ARCH_REGS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < ARCH_REGS; i++) m[i] = preg_t'(i);
  endtask

  task automatic chk_map();
    for (int i = 0; i < ARCH_REGS; i++) begin
      chk($sformatf("rrat_map[%0d]", i), 32'(bus.rrat_map[i]), 32'(m[i]));
    end
  endtask

  task automatic drive(input logic [1:0] v, input int rd0, input int pd0,
                       input int rd1, input int pd1);
    bus.commit_valid = v;
    bus.commit_rd[0] = areg_t'(rd0);
    bus.commit_pd[0] = preg_t'(pd0);
    bus.commit_rd[1] = areg_t'(rd1);
    bus.commit_pd[1] = preg_t'(pd1);
  endtask

  // Check outputs mid-cycle, retire accepted entries from the scoreboard, apply commits to the model.
  task automatic cycle();
    int   npop;
    logic exp_stall;
    @(negedge clk);
    exp_stall = (FREE_DEPTH - q.size()) < SS;
    chk("commit_stall", 32'(bus.commit_stall), 32'(exp_stall));
    for (int k = 0; k < SS; k++) begin
      chk($sformatf("free_valid[%0d]", k), 32'(bus.free_valid[k]), 32'(q.size() > k));
    end
    npop = 0;
    for (int k = 0; k < SS; k++) begin
      if (npop == k && k < q.size() && bus.free_ready[k]) begin
        chk($sformatf("free_pr[%0d]", k), 32'(bus.free_pr[k]), 32'(q[k]));
        npop++;
      end
    end
    repeat (npop) void'(q.pop_front());
    if (!exp_stall) begin
      for (int i = 0; i < SS; i++) begin
        if (bus.commit_valid[i] && bus.commit_rd[i] != '0) begin
          q.push_back(m[bus.commit_rd[i]]);
          m[bus.commit_rd[i]] = bus.commit_pd[i];
        end
      end
    end
    @(posedge clk);
    #1;
    chk_map();
  endtask

  initial begin
    rst            = 1'b0;
    bus.free_ready = 2'b00;
    drive(2'b00, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_free_valid", 32'(bus.free_valid), 32'd0);
    chk("reset_stall", 32'(bus.commit_stall), 32'd0);
    chk_map();
    rst = 1'b1;

    // Single commit, popped the cycle it appears.
    bus.free_ready = 2'b11;
    drive(2'b01, 5, 40, 0, 0);
    cycle();
    drive(2'b00, 0, 0, 0, 0);
    chk("map5", 32'(bus.rrat_map[5]), 32'd40);
    chk("free_valid_one", 32'(bus.free_valid), 32'b01);

    // Same rd in both slots.
    drive(2'b11, 3, 41, 3, 42);
    cycle();
    drive(2'b00, 0, 0, 0, 0);
    chk("map3", 32'(bus.rrat_map[3]), 32'd42);
    chk("free_pr0_dup", 32'(bus.free_pr[0]), 32'd3);
    chk("free_pr1_dup", 32'(bus.free_pr[1]), 32'd41);

    // x0 in slot 0 is neither mapped nor freed.
    drive(2'b11, 0, 50, 7, 51);
    cycle();
    drive(2'b00, 0, 0, 0, 0);
    chk("map0", 32'(bus.rrat_map[0]), 32'd0);
    chk("map7", 32'(bus.rrat_map[7]), 32'd51);
    cycle();

    // Fill with free list blocked until stall, then try committing under stall.
    bus.free_ready = 2'b00;
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 8 + 2*c, 20 + 2*c, 9 + 2*c, 21 + 2*c);
      cycle();
    end
    drive(2'b11, 16, 60, 17, 61);
    cycle();
    chk("stall_full", 32'(bus.commit_stall), 32'd1);
    chk("map16_ignored", 32'(bus.rrat_map[16]), 32'd16);
    drive(2'b00, 0, 0, 0, 0);

    // Gap in ready: slot1 ready only, no pops.
    bus.free_ready = 2'b10;
    cycle();
    chk("gap_head", 32'(bus.free_pr[0]), 32'd8);

    // Drain two per cycle; stall drops once count <= 6.
    bus.free_ready = 2'b11;
    cycle();
    chk("stall_dropped", 32'(bus.commit_stall), 32'd0);
    repeat (4) cycle();

    // Pointer wrap: push 20 PRs under random ready patterns.
    for (int c = 0; c < 10; c++) begin
      bus.free_ready = 2'($urandom_range(0, 3));
      drive(2'b11, 1 + (2*c) % 30, 30 + c, 2 + (2*c) % 30, 45 + c);
      cycle();
    end
    drive(2'b00, 0, 0, 0, 0);
    bus.free_ready = 2'b11;
    repeat (6) cycle();
    chk("wrap_drained", 32'(bus.free_valid), 32'd0);

    // Async reset with five entries held and a modified map.
    bus.free_ready = 2'b00;
    drive(2'b11, 20, 10, 21, 11);
    cycle();
    drive(2'b11, 22, 12, 23, 13);
    cycle();
    drive(2'b01, 24, 14, 0, 0);
    cycle();
    drive(2'b00, 0, 0, 0, 0);
    chk("pre_reset_valid", 32'(bus.free_valid), 32'b11);
    rst = 1'b0;
    model_reset();
    #2;
    chk("midrst_free_valid", 32'(bus.free_valid), 32'd0);
    chk("midrst_stall", 32'(bus.commit_stall), 32'd0);
    chk_map();
    rst = 1'b1;
    bus.free_ready = 2'b11;
    drive(2'b01, 9, 33, 0, 0);
    cycle();
    drive(2'b00, 0, 0, 0, 0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
